fnd_prog_clock_divider: RTL and testbench
=========================================

Name: fnd_prog_clock_divider

Overview:
- Runtime-programmable successor to the fixed half-period clock divider.
- Produces a toggled divided clock `o_clk`, a one-cycle enable strobe `o_tick`, and a wrapping FND digit-scan index `o_digit_sel`.
- Sits between the board clock and the FND multiplexer/refresh logic.
- Lets software or top-level logic change the scan rate without rebuilding, with glitch-free (period-boundary) updates.

Parameters:
- CNT_W, 32, width of half-period counter and divisor registers.
- DEFAULT_HALF, 5_000_000, half-period (in i_clk cycles) loaded at reset.
- NUM_DIGITS, 4, number of FND digits scanned; o_digit_sel wraps at NUM_DIGITS-1; legal range 2..16.
- SEL_W, 2, width of o_digit_sel; must satisfy 2**SEL_W >= NUM_DIGITS.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous active-high reset.
- i_enable  input  1  count enable; low freezes counter, o_clk and o_digit_sel.
- i_div_value  input  CNT_W  requested half-period in i_clk cycles.
- i_div_load  input  1  single-cycle strobe that captures i_div_value.
- o_clk  output  1  divided clock, toggles every half-period.
- o_tick  output  1  one-i_clk-cycle pulse on every o_clk toggle.
- o_digit_sel  output  SEL_W  current digit index.
- o_load_pending  output  1  a captured divisor is waiting for the next period boundary.
- o_half_active  output  CNT_W  half-period currently in force.

Behaviour:
- One clock domain. Reset is synchronous and active-high: all state changes only on posedge i_clk, and i_reset has priority over every other input.
- Reset values:
  - counter 0, o_clk 0, o_tick 0, o_digit_sel 0, o_load_pending 0.
  - o_half_active = DEFAULT_HALF; if DEFAULT_HALF is 0, o_half_active = 1.
- Effective half H: o_half_active; a value of 0 is never stored (0 is coerced to 1).
- Terminal count TC = i_enable && counter == H-1. On TC:
  - counter <= 0, o_clk <= ~o_clk, o_tick <= 1.
  - o_digit_sel <= (o_digit_sel == NUM_DIGITS-1) ? 0 : o_digit_sel+1.
- Otherwise, with i_enable high: counter increments, o_tick <= 0.
- With i_enable low: counter, o_clk and o_digit_sel hold; o_tick <= 0.
- H=1: o_tick is high every enabled cycle and o_clk toggles every cycle.
- Output rules:
  - All outputs are registered; no combinational path from inputs to outputs.
  - o_tick and o_clk change on the same edge.
- Divisor load:
  - i_div_load captures max(i_div_value,1) into a shadow register and sets o_load_pending.
  - At the next TC the shadow value moves into o_half_active and o_load_pending clears. The new H governs the period that starts after that edge; the current period is never truncated.
- Simultaneous load and TC in the same cycle: the new value goes straight into o_half_active and o_load_pending stays 0.
- Load while already pending: the shadow is overwritten (last load wins) and pending stays 1.
- Loads are accepted while i_enable is low; the transfer waits for a TC.
- Reset during a pending load: the pending value is discarded.
- Counter wrap: counter never exceeds H-1. If H is changed only at TC this invariant holds by construction; no modulo path is needed.

Optional Feature:
- Macro: FND_DIGIT_ONEHOT_EN.
- Defined:
  - Adds output port o_digit_an, width NUM_DIGITS, active-low one-hot anode drive: bit o_digit_sel is 0, all others 1.
  - Registered and updated on the same edge as o_digit_sel.
  - Reset value: all ones except bit 0 = 0.
- Undefined: the port does not exist and no anode logic is generated.

Test Plan:
- DEFAULT_HALF=4, i_enable=1 after reset -> o_tick pulses exactly every 4 cycles; o_clk period 8 cycles, 50% duty; o_digit_sel steps 0,1,2,3,0.
- Load i_div_value=2 mid-period (counter=1, H=4) -> o_load_pending=1 until the TC two cycles later; then half-periods of 2; o_half_active reads 2.
- i_div_load=1 with i_div_value=7 coincident with TC -> o_half_active=7 on that edge, o_load_pending never asserts; next tick 7 cycles later.
- Load 0 -> o_half_active=1 after the next TC; o_tick high every cycle while enabled.
- Drop i_enable for 10 cycles at counter=2 -> counter, o_clk and o_digit_sel frozen, no ticks; resume -> next tick after H-2 more cycles. Apply a load during the pause -> pending held, not applied until a TC.
- Assert i_reset while pending with o_digit_sel=3 -> next edge: all outputs at reset values, o_half_active=DEFAULT_HALF, pending cleared; with FND_DIGIT_ONEHOT_EN, o_digit_an=4'b1110.

Source files
------------

// File: rtl/fnd_prog_clock_divider.sv
// fnd_prog_clock_divider
//   Runtime-programmable half-period clock divider for FND (7-segment) digit
//   scanning. It produces a toggled divided clock, a one-cycle tick on every
//   toggle and a wrapping digit-scan index. A new divisor can be loaded at any
//   time. It takes effect only at a period boundary, so the divided clock never
//   sees a truncated half-period.
//
//   Optional feature (macro FND_DIGIT_ONEHOT_EN): adds o_digit_an, an
//   active-low one-hot anode drive that follows o_digit_sel.
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_enable        count enable; low freezes counter, o_clk and o_digit_sel
//   i_div_value     requested half-period in i_clk cycles (0 is treated as 1)
//   i_div_load      single-cycle strobe that captures i_div_value
//   o_clk           divided clock, toggles every half-period
//   o_tick          one-cycle pulse on every o_clk toggle
//   o_digit_sel     current digit index, wraps at NUM_DIGITS-1
//   o_load_pending  a captured divisor is waiting for the next period boundary
//   o_half_active   half-period currently in force
//   o_digit_an      (FND_DIGIT_ONEHOT_EN only) active-low one-hot anode drive

module fnd_prog_clock_divider #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 5_000_000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SEL_W        = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_div_value,
  input  logic             i_div_load,
  output logic             o_clk,
  output logic             o_tick,
  output logic [SEL_W-1:0] o_digit_sel,
  output logic             o_load_pending,
  output logic [CNT_W-1:0] o_half_active
`ifdef FND_DIGIT_ONEHOT_EN
  ,
  output logic [NUM_DIGITS-1:0] o_digit_an
`endif
);

  // A half-period of 0 is meaningless; it is coerced to 1 everywhere.
  localparam logic [CNT_W-1:0] DefaultH  = (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);
  localparam logic [SEL_W-1:0] LastDigit = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_clk;
  logic             r_tick;
  logic [SEL_W-1:0] r_sel;

  logic             w_tc;
  logic [CNT_W-1:0] w_div_sat;
  logic [SEL_W-1:0] w_sel_next;

  // r_half is never 0, so r_half - 1 cannot underflow.
  assign w_tc       = i_enable && (r_cnt == (r_half - CNT_W'(1)));
  assign w_div_sat  = (i_div_value == '0) ? CNT_W'(1) : i_div_value;
  assign w_sel_next = (r_sel == LastDigit) ? '0 : r_sel + SEL_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_half    <= DefaultH;
      r_shadow  <= DefaultH;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
      r_sel     <= '0;
    end else begin
      // Counter, divided clock and digit index.
      if (w_tc) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_tick <= 1'b1;
        r_sel  <= w_sel_next;
      end else begin
        if (i_enable) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        r_tick <= 1'b0;
      end

      // Divisor update only at a period boundary; a load coinciding with the
      // boundary bypasses the shadow register and never raises pending.
      if (w_tc) begin
        if (i_div_load) begin
          r_half    <= w_div_sat;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_half    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (i_div_load) begin
        r_shadow  <= w_div_sat;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_clk          = r_clk;
  assign o_tick         = r_tick;
  assign o_digit_sel    = r_sel;
  assign o_load_pending = r_pending;
  assign o_half_active  = r_half;

`ifdef FND_DIGIT_ONEHOT_EN
  logic [NUM_DIGITS-1:0] r_an;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_an <= ~NUM_DIGITS'(1);
    end else if (w_tc) begin
      r_an <= ~(NUM_DIGITS'(1) << w_sel_next);
    end
  end

  assign o_digit_an = r_an;
`endif

endmodule

// File: tb/tb_fnd_prog_clock_divider.sv
// Directed self-checking bench for fnd_prog_clock_divider with DEFAULT_HALF=4,
// NUM_DIGITS=4. Edges are numbered from reset release; expected values are
// written out by hand for each edge.

module tb_fnd_prog_clock_divider;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SEL_W = 2;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [CNT_W-1:0] div_value;
  logic             div_load;
  logic             dut_clk;
  logic             dut_tick;
  logic [SEL_W-1:0] dut_sel;
  logic             dut_pending;
  logic [CNT_W-1:0] dut_half;
`ifdef FND_DIGIT_ONEHOT_EN
  logic [3:0]       dut_an;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fnd_prog_clock_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(4),
    .NUM_DIGITS  (4),
    .SEL_W       (SEL_W)
  ) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_div_value   (div_value),
    .i_div_load    (div_load),
    .o_clk         (dut_clk),
    .o_tick        (dut_tick),
    .o_digit_sel   (dut_sel),
    .o_load_pending(dut_pending),
    .o_half_active (dut_half)
`ifdef FND_DIGIT_ONEHOT_EN
    ,
    .o_digit_an    (dut_an)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic t, input logic c, input int s);
    check_val({tag, ".tick"}, 32'(dut_tick), 32'(t));
    check_val({tag, ".clk"}, 32'(dut_clk), 32'(c));
    check_val({tag, ".sel"}, 32'(dut_sel), 32'(s));
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    step();
    step();
    check_out("reset", 1'b0, 1'b0, 0);
    check_val("reset.pending", 32'(dut_pending), 32'd0);
    check_val("reset.half", dut_half, 32'd4);

    // Free run with H=4: tick every 4th edge, o_clk and digit index step.
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_val($sformatf("run%0d.tick", i), 32'(dut_tick), 32'((i % 4) == 0));
      if ((i % 4) == 0) begin
        check_val($sformatf("run%0d.clk", i), 32'(dut_clk), 32'((i / 4) % 2));
        check_val($sformatf("run%0d.sel", i), 32'(dut_sel), 32'((i / 4) % 4));
      end
    end

    // Load 2 at counter=1 (edge 18); applied at TC on edge 20.
    step();
    div_load  = 1'b1;
    div_value = 32'd2;
    step();
    div_load  = 1'b0;
    check_val("ld2.pending", 32'(dut_pending), 32'd1);
    check_val("ld2.half_old", dut_half, 32'd4);
    check_val("ld2.tick", 32'(dut_tick), 32'd0);
    step();
    check_val("ld2.pending_hold", 32'(dut_pending), 32'd1);
    step();
    check_out("ld2.tc", 1'b1, 1'b1, 1);
    check_val("ld2.half_new", dut_half, 32'd2);
    check_val("ld2.pending_clr", 32'(dut_pending), 32'd0);
    step();
    check_val("h2.e21.tick", 32'(dut_tick), 32'd0);
    step();
    check_out("h2.e22", 1'b1, 1'b0, 2);
    step();
    step();
    check_out("h2.e24", 1'b1, 1'b1, 3);

    // Load 7 coincident with TC on edge 26.
    step();
    div_load  = 1'b1;
    div_value = 32'd7;
    step();
    div_load  = 1'b0;
    check_out("ld7.tc", 1'b1, 1'b0, 0);
    check_val("ld7.half", dut_half, 32'd7);
    check_val("ld7.pending", 32'(dut_pending), 32'd0);
    for (int i = 27; i <= 32; i++) begin
      step();
      check_val($sformatf("h7.e%0d.tick", i), 32'(dut_tick), 32'd0);
      check_val($sformatf("h7.e%0d.pending", i), 32'(dut_pending), 32'd0);
    end
    step();
    check_out("h7.e33", 1'b1, 1'b1, 1);

    // Load 0 -> coerced to 1 at next TC (edge 40).
    div_load  = 1'b1;
    div_value = 32'd0;
    step();
    div_load  = 1'b0;
    check_val("ld0.pending", 32'(dut_pending), 32'd1);
    check_val("ld0.half_old", dut_half, 32'd7);
    repeat (5) step();
    check_val("ld0.e39.tick", 32'(dut_tick), 32'd0);
    step();
    check_out("ld0.e40", 1'b1, 1'b0, 2);
    check_val("ld0.half", dut_half, 32'd1);
    check_val("ld0.pending_clr", 32'(dut_pending), 32'd0);
    step();
    check_out("h1.e41", 1'b1, 1'b1, 3);
    step();
    check_out("h1.e42", 1'b1, 1'b0, 0);
    step();
    check_out("h1.e43", 1'b1, 1'b1, 1);

    // Back to H=4 (coincident with TC since H=1), then pause at counter=2.
    div_load  = 1'b1;
    div_value = 32'd4;
    step();
    div_load  = 1'b0;
    check_out("ld4.e44", 1'b1, 1'b0, 2);
    check_val("ld4.half", dut_half, 32'd4);
    step();
    step();
    check_val("ld4.e46.tick", 32'(dut_tick), 32'd0);
    enable = 1'b0;
    for (int i = 47; i <= 56; i++) begin
      if (i == 50) begin
        div_load  = 1'b1;
        div_value = 32'd3;
      end
      step();
      div_load = 1'b0;
      check_out($sformatf("pause.e%0d", i), 1'b0, 1'b0, 2);
    end
    check_val("pause.pending", 32'(dut_pending), 32'd1);
    check_val("pause.half", dut_half, 32'd4);
    enable = 1'b1;
    step();
    check_val("resume.e57.tick", 32'(dut_tick), 32'd0);
    step();
    check_out("resume.e58", 1'b1, 1'b1, 3);
    check_val("resume.half", dut_half, 32'd3);
    check_val("resume.pending", 32'(dut_pending), 32'd0);

    // Reset while a load is pending and digit index is 3.
    div_load  = 1'b1;
    div_value = 32'd5;
    step();
    div_load  = 1'b0;
    check_val("rstp.pending", 32'(dut_pending), 32'd1);
    check_val("rstp.sel", 32'(dut_sel), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("rst2", 1'b0, 1'b0, 0);
    check_val("rst2.pending", 32'(dut_pending), 32'd0);
    check_val("rst2.half", dut_half, 32'd4);
`ifdef FND_DIGIT_ONEHOT_EN
    check_val("rst2.an", 32'(dut_an), 32'hE);
`endif
    repeat (3) step();
    check_val("post.e63.tick", 32'(dut_tick), 32'd0);
    step();
    check_out("post.e64", 1'b1, 1'b1, 1);
    check_val("post.half", dut_half, 32'd4);
`ifdef FND_DIGIT_ONEHOT_EN
    check_val("post.an", 32'(dut_an), 32'hD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
